// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel edge detector with a LOW/HIGH level FSM,
// selectable edge type, Mealy or Moore pulse output and saturating edge
// counters. Define EDGE_DEBOUNCE_EN to add a per-channel stability filter
// that accepts a new level only after it has been held for FILT_LEN cycles.
module edge_detect_multi #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 8,
  parameter int FILT_LEN = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       in_edge,
  input  logic [1:0]            edge_sel,
  input  logic                  mode,
  input  logic                  clr_cnt,
  output logic [N_CH-1:0]       out_edge,
  output logic                  any_edge,
  output logic [N_CH*CNT_W-1:0] edge_cnt
);

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} lvl_t;

  lvl_t            state     [N_CH];
  lvl_t            state_nxt [N_CH];
  logic [N_CH-1:0] lvl;
  logic [N_CH-1:0] diff;
  logic [N_CH-1:0] chg;
  logic [N_CH-1:0] qual_p0;
  logic [N_CH-1:0] pulse_p1;
  logic [CNT_W-1:0] cnt [N_CH];

  // Accepted level as a bit vector and raw disagreement with it
  always_comb begin
    lvl  = '0;
    diff = '0;
    for (int i = 0; i < N_CH; i++) begin
      lvl[i]  = (state[i] == HIGH);
      diff[i] = in_edge[i] ^ lvl[i];
    end
  end

`ifdef EDGE_DEBOUNCE_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic [3:0] stab [N_CH];

  // Count consecutive cycles of disagreement; restart once the level is accepted
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        stab[i] <= '0;
      end else if (diff[i] && !chg[i]) begin
        stab[i] <= stab[i] + 4'd1;
      end else begin
        stab[i] <= '0;
      end
    end
  end

  // A change is accepted on the FILT_LEN-th consecutive cycle of disagreement
  always_comb begin
    chg = '0;
    for (int i = 0; i < N_CH; i++) begin
      chg[i] = diff[i] && (stab[i] == FILT_LAST);
    end
  end
`else
  // FILT_LEN has no effect without the filter; tie it off
  logic [31:0] unused_filt;
  assign unused_filt = 32'(FILT_LEN);

  // Every disagreement is a change when unfiltered
  always_comb begin
    chg = diff;
  end
`endif

  // Level FSM state register
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        state[i] <= LOW;
      end else begin
        state[i] <= state_nxt[i];
      end
    end
  end

  // Next level and edge qualification against edge_sel
  always_comb begin
    qual_p0 = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_nxt[i] = state[i];
      if (chg[i]) begin
        if (state[i] == LOW) begin
          state_nxt[i] = HIGH;
          qual_p0[i]   = (edge_sel == 2'b00) || (edge_sel == 2'b10);
        end else begin
          state_nxt[i] = LOW;
          qual_p0[i]   = (edge_sel == 2'b01) || (edge_sel == 2'b10);
        end
      end
    end
  end

  // ---- stage p0 -> p1: registered pulse for Moore mode ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_p1 <= '0;
    end else begin
      pulse_p1 <= qual_p0;
    end
  end

  // Saturating per-channel counters; clear beats increment
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset || clr_cnt) begin
        cnt[i] <= '0;
      end else if (qual_p0[i] && (cnt[i] != {CNT_W{1'b1}})) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Output select; reset blanks both the Mealy and Moore paths
  always_comb begin
    out_edge = reset ? '0 : (mode ? pulse_p1 : qual_p0);
    any_edge = |out_edge;
  end

  // Pack the counters onto the output bus
  always_comb begin
    edge_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      edge_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi: two instances (8-bit and 2-bit counters)
// share stimulus and are checked against a cycle-level behavioural model.
module tb_edge_detect_multi;
  localparam int N = 4;
`ifdef EDGE_DEBOUNCE_EN
  localparam int FILT = 3;
`else
  localparam int FILT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] in_edge = '0;
  logic [1:0] edge_sel = 2'b00;
  logic mode = 1'b0;
  logic clr_cnt = 1'b0;
  logic [N-1:0] out8, out2;
  logic any8, any2;
  logic [N*8-1:0] cnt8;
  logic [N*2-1:0] cnt2;

  int compared = 0;
  int mismatched = 0;

  // model state
  bit lvl_m [N];
  int run_m [N];
  int run_cur [N];
  bit chg_m [N];
  bit qual_m [N];
  bit mreg_m [N];
  int c8_m [N];
  int c2_m [N];
  logic [N-1:0] exp_out;
  logic exp_any;
  logic [N*8-1:0] exp_c8;
  logic [N*2-1:0] exp_c2;

  always #5 clk = ~clk;

  edge_detect_multi #(.N_CH(N), .CNT_W(8), .FILT_LEN(3)) u8 (
    .clk(clk), .reset(reset), .in_edge(in_edge), .edge_sel(edge_sel),
    .mode(mode), .clr_cnt(clr_cnt), .out_edge(out8), .any_edge(any8), .edge_cnt(cnt8));

  edge_detect_multi #(.N_CH(N), .CNT_W(2), .FILT_LEN(3)) u2 (
    .clk(clk), .reset(reset), .in_edge(in_edge), .edge_sel(edge_sel),
    .mode(mode), .clr_cnt(clr_cnt), .out_edge(out2), .any_edge(any2), .edge_cnt(cnt2));

  // Expected outputs for the current cycle from current inputs and model state
  function automatic void model_eval();
    bit rising, falling;
    for (int i = 0; i < N; i++) begin
      run_cur[i] = (in_edge[i] != lvl_m[i]) ? run_m[i] + 1 : 0;
      chg_m[i]   = (run_cur[i] >= FILT);
      rising     = chg_m[i] && !lvl_m[i];
      falling    = chg_m[i] && lvl_m[i];
      qual_m[i]  = (rising  && (edge_sel == 2'd0 || edge_sel == 2'd2)) ||
                   (falling && (edge_sel == 2'd1 || edge_sel == 2'd2));
      exp_out[i] = reset ? 1'b0 : (mode ? mreg_m[i] : qual_m[i]);
      exp_c8[i*8 +: 8] = 8'(c8_m[i]);
      exp_c2[i*2 +: 2] = 2'(c2_m[i]);
    end
    exp_any = |exp_out;
  endfunction

  // Model state update at the clock edge
  function automatic void model_tick();
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        lvl_m[i] = 0; run_m[i] = 0; mreg_m[i] = 0; c8_m[i] = 0; c2_m[i] = 0;
      end else begin
        run_m[i] = chg_m[i] ? 0 : run_cur[i];
        if (chg_m[i]) lvl_m[i] = !lvl_m[i];
        mreg_m[i] = qual_m[i];
        if (clr_cnt) begin
          c8_m[i] = 0; c2_m[i] = 0;
        end else if (qual_m[i]) begin
          c8_m[i] = (c8_m[i] < 255) ? c8_m[i] + 1 : 255;
          c2_m[i] = (c2_m[i] < 3) ? c2_m[i] + 1 : 3;
        end
      end
    end
  endfunction

  task automatic half();
    @(negedge clk);
    model_eval();
  endtask

  task automatic adv();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_for(input int n);
    reset = 1'b1;
    repeat (n) begin half(); adv(); end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mode = 1'b0; edge_sel = 2'b10; reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_edge = 4'($urandom_range(0, 15));
      mode = c[0];
      half();
      compared++;
      if (out8 !== exp_out || any8 !== exp_any || cnt8 !== exp_c8 || out2 !== exp_out || any2 !== exp_any || cnt2 !== exp_c2) begin
        mismatched++;
        $display("FAIL reset_model c=%0d out=%b any=%b cnt8=%h cnt2=%h, expected out=%b any=%b cnt8=%h cnt2=%h", c, out8, any8, cnt8, cnt2, exp_out, exp_any, exp_c8, exp_c2);
      end
      compared++;
      if (out8 !== 4'b0000 || any8 !== 1'b0 || cnt8 !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_quiet c=%0d out=%b any=%b cnt8=%h, expected 0", c, out8, any8, cnt8);
      end
      adv();
    end
  endtask

  task automatic test_mealy_rise();
    in_edge = '0; mode = 1'b0; edge_sel = 2'b00;
    reset_for(2);
    for (int c = 0; c < 13; c++) begin
      if (c == 10) in_edge[0] = 1'b1;
      half();
      compared++;
      if (out8 !== exp_out || any8 !== exp_any || cnt8 !== exp_c8 || out2 !== exp_out || any2 !== exp_any || cnt2 !== exp_c2) begin
        mismatched++;
        $display("FAIL mealy_model c=%0d out=%b any=%b cnt8=%h cnt2=%h, expected out=%b any=%b cnt8=%h cnt2=%h", c, out8, any8, cnt8, cnt2, exp_out, exp_any, exp_c8, exp_c2);
      end
`ifndef EDGE_DEBOUNCE_EN
      if (c == 10 || c == 11) begin
        compared++;
        if (out8 !== ((c == 10) ? 4'b0001 : 4'b0000) || (c == 11 && cnt8[7:0] !== 8'd1)) begin
          mismatched++;
          $display("FAIL mealy_rise c=%0d out=%b cnt0=%0d, expected out=%b cnt0=%0d", c, out8, cnt8[7:0], (c == 10) ? 4'b0001 : 4'b0000, (c == 10) ? 0 : 1);
        end
      end
`endif
      adv();
    end
  endtask

  task automatic test_moore_both();
    in_edge = '0; mode = 1'b1; edge_sel = 2'b10;
    reset_for(2);
    for (int c = 0; c < 14; c++) begin
      if (c == 10) in_edge[2] = 1'b1;
      if (c == 11) in_edge[2] = 1'b0;
      half();
      compared++;
      if (out8 !== exp_out || any8 !== exp_any || cnt8 !== exp_c8 || out2 !== exp_out || any2 !== exp_any || cnt2 !== exp_c2) begin
        mismatched++;
        $display("FAIL moore_model c=%0d out=%b any=%b cnt8=%h cnt2=%h, expected out=%b any=%b cnt8=%h cnt2=%h", c, out8, any8, cnt8, cnt2, exp_out, exp_any, exp_c8, exp_c2);
      end
`ifndef EDGE_DEBOUNCE_EN
      if (c >= 10) begin
        compared++;
        if (out8[2] !== (c == 11 || c == 12) || (c == 13 && cnt8[23:16] !== 8'd2)) begin
          mismatched++;
          $display("FAIL moore_both c=%0d out2=%b cnt2=%0d, expected out2=%b cnt2=2", c, out8[2], cnt8[23:16], (c == 11 || c == 12));
        end
      end
`endif
      adv();
    end
  endtask

  task automatic test_saturate();
    in_edge = '0; mode = 1'b0; edge_sel = 2'b00; clr_cnt = 1'b0;
    reset_for(2);
    for (int c = 0; c < 13; c++) begin
      in_edge[1] = (c < 10) ? !c[0] : 1'b0;
      if (c == 11) in_edge[1] = 1'b1;
      clr_cnt = (c == 11);
      half();
      compared++;
      if (out8 !== exp_out || any8 !== exp_any || cnt8 !== exp_c8 || out2 !== exp_out || any2 !== exp_any || cnt2 !== exp_c2) begin
        mismatched++;
        $display("FAIL sat_model c=%0d out=%b cnt8=%h cnt2=%h, expected out=%b cnt8=%h cnt2=%h", c, out8, cnt8, cnt2, exp_out, exp_c8, exp_c2);
      end
`ifndef EDGE_DEBOUNCE_EN
      if (c == 11 || c == 12) begin
        compared++;
        if (cnt2[3:2] !== ((c == 11) ? 2'd3 : 2'd0)) begin
          mismatched++;
          $display("FAIL saturate c=%0d cnt1=%0d, expected %0d", c, cnt2[3:2], (c == 11) ? 3 : 0);
        end
      end
`endif
      adv();
    end
    clr_cnt = 1'b0;
  endtask

`ifdef EDGE_DEBOUNCE_EN
  task automatic test_debounce();
    in_edge = '0; mode = 1'b0; edge_sel = 2'b00;
    reset_for(2);
    for (int c = 0; c < 12; c++) begin
      in_edge[3] = (c >= 2 && c < 4) || (c >= 7 && c < 12);
      half();
      compared++;
      if (out8 !== exp_out || any8 !== exp_any || cnt8 !== exp_c8 || out2 !== exp_out || any2 !== exp_any || cnt2 !== exp_c2) begin
        mismatched++;
        $display("FAIL deb_model c=%0d out=%b cnt8=%h, expected out=%b cnt8=%h", c, out8, cnt8, exp_out, exp_c8);
      end
      compared++;
      if (out8[3] !== (c == 9)) begin
        mismatched++;
        $display("FAIL debounce c=%0d out3=%b, expected %b", c, out8[3], (c == 9));
      end
      adv();
    end
  endtask
`endif

  task automatic test_reset_high();
    in_edge = 4'hf; mode = 1'b0; edge_sel = 2'b00; reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      reset = (c < 3);
      half();
      compared++;
      if (out8 !== exp_out || any8 !== exp_any || cnt8 !== exp_c8 || out2 !== exp_out || any2 !== exp_any || cnt2 !== exp_c2) begin
        mismatched++;
        $display("FAIL rsthi_model c=%0d out=%b cnt8=%h cnt2=%h, expected out=%b cnt8=%h cnt2=%h", c, out8, cnt8, cnt2, exp_out, exp_c8, exp_c2);
      end
      if (c < 3) begin
        compared++;
        if (out8 !== 4'b0000 || any8 !== 1'b0) begin
          mismatched++;
          $display("FAIL rsthi_during c=%0d out=%b any=%b, expected 0000 0", c, out8, any8);
        end
      end
`ifndef EDGE_DEBOUNCE_EN
      if (c == 3 || c == 4) begin
        compared++;
        if (out8 !== ((c == 3) ? 4'hf : 4'h0) || (c == 4 && cnt8 !== 32'h01010101)) begin
          mismatched++;
          $display("FAIL rsthi_release c=%0d out=%b cnt8=%h, expected out=%b cnt8=01010101", c, out8, cnt8, (c == 3) ? 4'hf : 4'h0);
        end
      end
`endif
      adv();
    end
  endtask

  task automatic test_sel_none();
    in_edge = '0; mode = 1'b0; edge_sel = 2'b11;
    reset_for(2);
    for (int c = 0; c < 18; c++) begin
      if (c < 8) in_edge[0] = c[0];
      else if (c < 12) in_edge[0] = 1'b1;
      else in_edge[0] = 1'b0;
      if (c == 11) edge_sel = 2'b01;
      half();
      compared++;
      if (out8 !== exp_out || any8 !== exp_any || cnt8 !== exp_c8 || out2 !== exp_out || any2 !== exp_any || cnt2 !== exp_c2) begin
        mismatched++;
        $display("FAIL selnone_model c=%0d out=%b cnt8=%h, expected out=%b cnt8=%h", c, out8, cnt8, exp_out, exp_c8);
      end
`ifndef EDGE_DEBOUNCE_EN
      compared++;
      if (out8 !== ((c == 12) ? 4'b0001 : 4'b0000) || cnt8 !== ((c > 12) ? 32'h1 : 32'h0)) begin
        mismatched++;
        $display("FAIL sel_none c=%0d out=%b cnt8=%h, expected out=%b cnt8=%h", c, out8, cnt8, (c == 12) ? 4'b0001 : 4'b0000, (c > 12) ? 32'h1 : 32'h0);
      end
`endif
      adv();
    end
  endtask

  task automatic test_back_to_back();
    in_edge = '0; mode = 1'b1; edge_sel = 2'b10;
    reset_for(2);
    for (int c = 0; c < 12; c++) begin
      in_edge = (c < 10 && !c[0]) ? 4'hf : 4'h0;
      half();
      compared++;
      if (out8 !== exp_out || any8 !== exp_any || cnt8 !== exp_c8 || out2 !== exp_out || any2 !== exp_any || cnt2 !== exp_c2) begin
        mismatched++;
        $display("FAIL b2b_model c=%0d out=%b cnt8=%h, expected out=%b cnt8=%h", c, out8, cnt8, exp_out, exp_c8);
      end
`ifndef EDGE_DEBOUNCE_EN
      if (c >= 1) begin
        compared++;
        if (out8 !== ((c <= 10) ? 4'hf : 4'h0) || (c == 11 && cnt8 !== 32'h0a0a0a0a)) begin
          mismatched++;
          $display("FAIL back_to_back c=%0d out=%b cnt8=%h, expected out=%b cnt8=0a0a0a0a", c, out8, cnt8, (c <= 10) ? 4'hf : 4'h0);
        end
      end
`endif
      adv();
    end
  endtask

  task automatic test_random();
    reset_for(2);
    for (int c = 0; c < 500; c++) begin
      in_edge  = 4'($urandom_range(0, 15));
      edge_sel = 2'($urandom_range(0, 3));
      mode     = 1'($urandom_range(0, 1));
      clr_cnt  = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 39) == 0);
      half();
      compared++;
      if (out8 !== exp_out || any8 !== exp_any || cnt8 !== exp_c8 || out2 !== exp_out || any2 !== exp_any || cnt2 !== exp_c2) begin
        mismatched++;
        $display("FAIL random c=%0d in=%b sel=%0d mode=%b out=%b any=%b cnt8=%h cnt2=%h, expected out=%b any=%b cnt8=%h cnt2=%h", c, in_edge, edge_sel, mode, out8, any8, cnt8, cnt2, exp_out, exp_any, exp_c8, exp_c2);
      end
      adv();
    end
    reset = 1'b0; clr_cnt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      lvl_m[i] = 0; run_m[i] = 0; mreg_m[i] = 0; c8_m[i] = 0; c2_m[i] = 0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mealy_rise();
    test_moore_both();
    test_saturate();
`ifdef EDGE_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_high();
    test_sel_none();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
